// File: rtl/vss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vss_pkg                                                         |
// | Purpose  : Shared types and helpers for the video_source_switch slice.     |
// |            - vss_state_t : switch FSM states                               |
// |            - vss_idx_w() : index width for n items, never below 1          |
// |            - MUTE_CNT_W  : width of the post-switch mute frame counter     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vss_pkg;

  localparam int MUTE_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_VS = 2'd1,
    MUTE    = 2'd2
  } vss_state_t;

  function automatic int vss_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vss_vs_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vss_vs_edge                                                     |
// | Purpose  : Per-source vsync rising-edge (frame start) detector. The        |
// |            previous vsync is only sampled on pix_ce cycles, so an edge is  |
// |            seen exactly once per frame in the pixel domain.                |
// | Ports    : clk_100m, reset_n (async, active-low), pix_ce                   |
// |            vs_i[NUM_SRC]          per-source vsync                          |
// |            frame_start_o[NUM_SRC] combinational frame-start flags          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vss_vs_edge #(
  parameter int NUM_SRC = 2
) (
  input  logic               clk_100m,
  input  logic               reset_n,
  input  logic               pix_ce,
  input  logic [NUM_SRC-1:0] vs_i,
  output logic [NUM_SRC-1:0] frame_start_o
);

  logic [NUM_SRC-1:0] vs_prev_q;

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q <= '0;
    end else if (pix_ce) begin
      vs_prev_q <= vs_i;
    end
  end

  assign frame_start_o = {NUM_SRC{pix_ce}} & vs_i & ~vs_prev_q;

endmodule
`default_nettype wire

// File: rtl/video_source_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_source_switch                                             |
// | Purpose  : N-input pixel-stream selector for the HDMI TX path. Source      |
// |            changes take effect at an old-source frame start (or after a    |
// |            vsync timeout), then the new source is muted for MUTE_FRAMES.   |
// | Ports    : clk_100m, reset_n (async, active-low), pix_ce                   |
// |            src_de/hs/vs[NUM_SRC], src_rgb[NUM_SRC*3*BPC]                   |
// |            sel_req, sel_req_valid -> sel_busy, sel_err, sel_active         |
// |            out_de, out_hs, out_vs, out_r, out_g, out_b (registered)        |
// | Option   : VIDEO_SOURCE_SWITCH_CNT_EN adds sw_cnt[15:0] (completed         |
// |            switches) and sw_timeout[7:0] (forced switches), saturating.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module video_source_switch
  import vss_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int BPC         = 12,
  parameter int DEFAULT_SRC = 0,
  parameter int MUTE_FRAMES = 2,
  parameter int VS_TIMEOUT  = 2000000
) (
  input  logic                              clk_100m,
  input  logic                              reset_n,
  input  logic                              pix_ce,
  input  logic [NUM_SRC-1:0]                src_de,
  input  logic [NUM_SRC-1:0]                src_hs,
  input  logic [NUM_SRC-1:0]                src_vs,
  input  logic [NUM_SRC*3*BPC-1:0]          src_rgb,
  input  logic [vss_idx_w(NUM_SRC)-1:0]     sel_req,
  input  logic                              sel_req_valid,
  output logic                              sel_busy,
  output logic                              sel_err,
  output logic [vss_idx_w(NUM_SRC)-1:0]     sel_active,
  output logic                              out_de,
  output logic                              out_hs,
  output logic                              out_vs,
  output logic [BPC-1:0]                    out_r,
  output logic [BPC-1:0]                    out_g,
  output logic [BPC-1:0]                    out_b
`ifdef VIDEO_SOURCE_SWITCH_CNT_EN
  ,
  output logic [15:0]                       sw_cnt,
  output logic [7:0]                        sw_timeout
`endif
);

  localparam int IDX_W = vss_idx_w(NUM_SRC);
  localparam int TMO_W = vss_idx_w(VS_TIMEOUT);
  localparam logic [IDX_W-1:0]      DEF_IDX   = IDX_W'(DEFAULT_SRC);
  localparam logic [IDX_W:0]        NUM_SRC_C = (IDX_W+1)'(NUM_SRC);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(VS_TIMEOUT - 1);
  localparam logic [MUTE_CNT_W-1:0] MUTE_INIT = MUTE_CNT_W'(MUTE_FRAMES);

  vss_state_t             state_q, state_d;
  logic [IDX_W-1:0]       sel_active_q, sel_active_d;
  logic [IDX_W-1:0]       pend_sel_q, pend_sel_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [MUTE_CNT_W-1:0]  mute_cnt_q, mute_cnt_d;
  logic                   sel_err_q, sel_err_d;

  logic [NUM_SRC-1:0]     frame_start;
  logic                   cur_de, cur_hs, cur_vs, cur_fs;
  logic [3*BPC-1:0]       cur_rgb;
  logic                   req_bad_range;
  logic                   tmo_hit;
  logic                   switch_done;
  logic                   switch_forced;

  vss_vs_edge #(
    .NUM_SRC(NUM_SRC)
  ) u_vs_edge (
    .clk_100m     (clk_100m),
    .reset_n      (reset_n),
    .pix_ce       (pix_ce),
    .vs_i         (src_vs),
    .frame_start_o(frame_start)
  );

  // Currently routed source. In MUTE this is already the new source, so its
  // frame starts drive the mute countdown.
  always_comb begin
    cur_de  = 1'b0;
    cur_hs  = 1'b0;
    cur_vs  = 1'b0;
    cur_fs  = 1'b0;
    cur_rgb = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_active_q == IDX_W'(k)) begin
        cur_de  = src_de[k];
        cur_hs  = src_hs[k];
        cur_vs  = src_vs[k];
        cur_fs  = frame_start[k];
        cur_rgb = src_rgb[k*3*BPC +: 3*BPC];
      end
    end
  end

  assign req_bad_range = ({1'b0, sel_req} >= NUM_SRC_C);
  assign tmo_hit       = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    sel_active_d  = sel_active_q;
    pend_sel_d    = pend_sel_q;
    tmo_cnt_d     = tmo_cnt_q;
    mute_cnt_d    = mute_cnt_q;
    sel_err_d     = 1'b0;
    switch_done   = 1'b0;
    switch_forced = 1'b0;

    // Range check wins over busy check; either yields a single error pulse.
    if (sel_req_valid && (req_bad_range || (state_q != RUN))) begin
      sel_err_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (sel_req_valid && !req_bad_range && (sel_req != sel_active_q)) begin
          pend_sel_d = sel_req;
          tmo_cnt_d  = '0;
          state_d    = WAIT_VS;
        end
      end
      WAIT_VS: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A vsync edge coinciding with timeout expiry is one switch, not forced.
        if (cur_fs || tmo_hit) begin
          sel_active_d  = pend_sel_q;
          mute_cnt_d    = MUTE_INIT;
          state_d       = (MUTE_FRAMES == 0) ? RUN : MUTE;
          switch_done   = 1'b1;
          switch_forced = tmo_hit && !cur_fs;
        end
      end
      MUTE: begin
        if (cur_fs) begin
          if (mute_cnt_q <= MUTE_CNT_W'(1)) begin
            mute_cnt_d = '0;
            state_d    = RUN;
          end else begin
            mute_cnt_d = mute_cnt_q - MUTE_CNT_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      sel_active_q <= DEF_IDX;
      pend_sel_q   <= '0;
      tmo_cnt_q    <= '0;
      mute_cnt_q   <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_active_q <= sel_active_d;
      pend_sel_q   <= pend_sel_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mute_cnt_q   <= mute_cnt_d;
      sel_err_q    <= sel_err_d;
    end
  end

  // Output pipeline: one register stage, advanced only on pix_ce. Sync pulses
  // keep flowing while muted so the sink stays locked to the new source.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      out_de <= 1'b0;
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
    end else if (pix_ce) begin
      out_hs <= cur_hs;
      out_vs <= cur_vs;
      if (state_q == MUTE) begin
        out_de <= 1'b0;
        out_r  <= '0;
        out_g  <= '0;
        out_b  <= '0;
      end else begin
        out_de <= cur_de;
        out_r  <= cur_rgb[3*BPC-1:2*BPC];
        out_g  <= cur_rgb[2*BPC-1:BPC];
        out_b  <= cur_rgb[BPC-1:0];
      end
    end
  end

  assign sel_busy   = (state_q != RUN);
  assign sel_err    = sel_err_q;
  assign sel_active = sel_active_q;

`ifdef VIDEO_SOURCE_SWITCH_CNT_EN
  logic [15:0] sw_cnt_q;
  logic [7:0]  sw_timeout_q;

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      sw_cnt_q     <= '0;
      sw_timeout_q <= '0;
    end else begin
      if (switch_done && (sw_cnt_q != 16'hFFFF)) begin
        sw_cnt_q <= sw_cnt_q + 16'd1;
      end
      if (switch_forced && (sw_timeout_q != 8'hFF)) begin
        sw_timeout_q <= sw_timeout_q + 8'd1;
      end
    end
  end

  assign sw_cnt     = sw_cnt_q;
  assign sw_timeout = sw_timeout_q;
`else
  logic unused_cnt;
  assign unused_cnt = switch_done ^ switch_forced;
`endif

endmodule
`default_nettype wire
